// File: rtl/mult_arbiter.sv
// Two-requester round-robin front end for one shared, externally pipelined multiplier.
// Exactly one operation is in flight; the product is captured MULT_LAT+1 edges after accept.
module mult_arbiter #(
  parameter int M        = 8,
  parameter int MULT_LAT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  input  logic [M-1:0]   req0_a,
  input  logic [M-1:0]   req0_b,
  input  logic           req1_valid,
  input  logic [M-1:0]   req1_a,
  input  logic [M-1:0]   req1_b,
  output logic           req0_ready,
  output logic           req1_ready,
  output logic [M-1:0]   mult_a,
  output logic [M-1:0]   mult_b,
  input  logic [2*M-1:0] mult_p,
  output logic           rsp_valid,
  output logic           rsp_id,
  output logic [2*M-1:0] rsp_p,
  output logic           busy
);

  localparam int CW = $clog2(MULT_LAT + 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(MULT_LAT);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic            owner_q;
  logic            last_grant_q;
  logic [M-1:0]    mult_a_q;
  logic [M-1:0]    mult_b_q;
  logic [2*M-1:0]  rsp_p_q;
  logic            rsp_id_q;
  logic            rsp_valid_q;

  logic            gnt_vld_d;
  logic            gnt_id_d;
  logic [M-1:0]    gnt_a_d;
  logic [M-1:0]    gnt_b_d;

  // Round-robin grant: on a tie the requester not served last wins.
  always_comb begin
    gnt_vld_d = 1'b0;
    gnt_id_d  = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt_vld_d = 1'b1;
      gnt_id_d  = ~last_grant_q;
    end else if (req0_valid) begin
      gnt_vld_d = 1'b1;
      gnt_id_d  = 1'b0;
    end else if (req1_valid) begin
      gnt_vld_d = 1'b1;
      gnt_id_d  = 1'b1;
    end else begin
      gnt_vld_d = 1'b0;
      gnt_id_d  = 1'b0;
    end
  end

  // Operand select for the granted requester.
  always_comb begin
    gnt_a_d = req0_a;
    gnt_b_d = req0_b;
    if (gnt_id_d) begin
      gnt_a_d = req1_a;
      gnt_b_d = req1_b;
    end else begin
      gnt_a_d = req0_a;
      gnt_b_d = req0_b;
    end
  end

  assign req0_ready = (state_q == ST_IDLE) && gnt_vld_d && !gnt_id_d;
  assign req1_ready = (state_q == ST_IDLE) && gnt_vld_d &&  gnt_id_d;

  // Issue/wait FSM with registered operand and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      mult_a_q     <= '0;
      mult_b_q     <= '0;
      rsp_p_q      <= '0;
      rsp_id_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (gnt_vld_d) begin
            mult_a_q     <= gnt_a_d;
            mult_b_q     <= gnt_b_d;
            owner_q      <= gnt_id_d;
            last_grant_q <= gnt_id_d;
            cnt_q        <= '0;
            state_q      <= ST_WAIT;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          // cnt_q counts edges spent in WAIT; the multiplier output is settled once it reaches MULT_LAT.
          if (cnt_q == CNT_LAST) begin
            rsp_p_q     <= mult_p;
            rsp_id_q    <= owner_q;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign mult_a    = mult_a_q;
  assign mult_b    = mult_b_q;
  assign rsp_p     = rsp_p_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_valid = rsp_valid_q;
  assign busy      = (state_q == ST_WAIT);

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter: one MULT_LAT=1 instance under full test plus
// MULT_LAT=0 and MULT_LAT=3 instances for latency; multipliers modelled here.
module tb_mult_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [7:0]  req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready;
  logic [7:0]  mult_a, mult_b;
  logic [15:0] mult_p;
  logic        rsp_valid, rsp_id, busy;
  logic [15:0] rsp_p;

  logic        x_valid;
  logic [7:0]  x_a, x_b;
  logic        r0_ready0, r1_ready0, v0, id0, busy0;
  logic        r0_ready3, r1_ready3, v3, id3, busy3;
  logic [7:0]  ma0, mb0, ma3, mb3;
  logic [15:0] mp0, mp3, p0, p3, s3a, s3b;

  mult_arbiter #(.M(8), .MULT_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .mult_a(mult_a), .mult_b(mult_b), .mult_p(mult_p),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_p(rsp_p), .busy(busy)
  );

  mult_arbiter #(.M(8), .MULT_LAT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(x_valid), .req0_a(x_a), .req0_b(x_b),
    .req1_valid(1'b0), .req1_a(8'h00), .req1_b(8'h00),
    .req0_ready(r0_ready0), .req1_ready(r1_ready0),
    .mult_a(ma0), .mult_b(mb0), .mult_p(mp0),
    .rsp_valid(v0), .rsp_id(id0), .rsp_p(p0), .busy(busy0)
  );

  mult_arbiter #(.M(8), .MULT_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(x_valid), .req0_a(x_a), .req0_b(x_b),
    .req1_valid(1'b0), .req1_a(8'h00), .req1_b(8'h00),
    .req0_ready(r0_ready3), .req1_ready(r1_ready3),
    .mult_a(ma3), .mult_b(mb3), .mult_p(mp3),
    .rsp_valid(v3), .rsp_id(id3), .rsp_p(p3), .busy(busy3)
  );

  // External shared multipliers with 1, 0 and 3 register stages.
  always @(posedge clk) mult_p <= {8'h00, mult_a} * {8'h00, mult_b};
  assign mp0 = {8'h00, ma0} * {8'h00, mb0};
  always @(posedge clk) begin
    s3a <= {8'h00, ma3} * {8'h00, mb3};
    s3b <= s3a;
    mp3 <= s3b;
  end

  int pass_cnt = 0;
  int tot_cnt  = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tot_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single-requester operation from IDLE; expects result MULT_LAT+1 = 2 edges after accept.
  task automatic do_op(input string nm, input logic id, input logic [7:0] a,
                       input logic [7:0] b, input logic [15:0] exp_p);
    int lat;
    lat = 0;
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    #1;
    chk({nm, "_ready"}, id ? req1_ready : req0_ready, 32'd1);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk({nm, "_mult_a"}, mult_a, a);
    chk({nm, "_mult_b"}, mult_b, b);
    chk({nm, "_busy"}, busy, 32'd1);
    for (int k = 1; k <= 20; k++) begin
      step();
      if (rsp_valid) begin lat = k; break; end
    end
    chk({nm, "_lat"}, lat, 32'd2);
    chk({nm, "_id"}, rsp_id, id);
    chk({nm, "_p"}, rsp_p, exp_p);
  endtask

  typedef struct {
    logic        id;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int busy_cnt, nrsp, hits, lat0, lat3;
    int rsp_e[8];
    logic rsp_i[8];
    logic [15:0] rsp_v[8];
    logic [15:0] exp_pp;

    vecs[0] = '{1'b0, 8'hAA, 8'hAA, 16'h70E4};
    vecs[1] = '{1'b1, 8'h03, 8'h05, 16'h000F};
    vecs[2] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
    vecs[3] = '{1'b1, 8'h00, 8'h7F, 16'h0000};
    vecs[4] = '{1'b0, 8'h80, 8'h02, 16'h0100};
    vecs[5] = '{1'b1, 8'hFF, 8'h01, 16'h00FF};

    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 8'h00; req0_b = 8'h00; req1_a = 8'h00; req1_b = 8'h00;
    x_valid = 1'b0; x_a = 8'h00; x_b = 8'h00;
    #2;
    chk("rst_mult_a", mult_a, 32'd0);
    chk("rst_mult_b", mult_b, 32'd0);
    chk("rst_rsp_p", rsp_p, 32'd0);
    chk("rst_rsp_id", rsp_id, 32'd0);
    chk("rst_rsp_valid", rsp_valid, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_ready0", req0_ready, 32'd0);
    chk("rst_ready1", req1_ready, 32'd0);
    step();
    step();
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      do_op($sformatf("vec%0d", i), vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].p);

    // Both requesters saturated straight out of reset: req0 wins first, then strict alternation.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_a = 8'hFF; req0_b = 8'hFF;
    req1_valid = 1'b1; req1_a = 8'h03; req1_b = 8'h05;
    busy_cnt = 0;
    nrsp = 0;
    for (int e = 0; e < 20; e++) begin
      step();
      if (e == 0) chk("first_edge_accept", busy, 32'd1);
      if (e < 18 && busy) busy_cnt++;
      if (rsp_valid && nrsp < 8) begin
        rsp_e[nrsp] = e; rsp_i[nrsp] = rsp_id; rsp_v[nrsp] = rsp_p; nrsp++;
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("sat_nrsp", nrsp, 32'd6);
    chk("sat_busy_2of3", busy_cnt, 32'd12);
    for (int k = 0; k < 6 && k < nrsp; k++) begin
      exp_pp = (k % 2 == 0) ? 16'hFE01 : 16'h000F;
      chk($sformatf("sat%0d_edge", k), rsp_e[k], 2 + 3 * k);
      chk($sformatf("sat%0d_id", k), rsp_i[k], k % 2);
      chk($sformatf("sat%0d_p", k), rsp_v[k], exp_pp);
    end
    for (int k = 0; k < 4; k++) step();

    // req1 arrives during req0's WAIT and is accepted in the response cycle.
    req0_valid = 1'b1; req0_a = 8'h11; req0_b = 8'h10;
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 8'h07; req1_b = 8'h09;
    #1;
    chk("wait_ready1_a", req1_ready, 32'd0);
    step();
    chk("wait_ready1_b", req1_ready, 32'd0);
    chk("wait_no_rsp", rsp_valid, 32'd0);
    step();
    chk("idle_rsp_valid", rsp_valid, 32'd1);
    chk("idle_rsp_id", rsp_id, 32'd0);
    chk("idle_rsp_p", rsp_p, 32'h0110);
    chk("idle_ready1", req1_ready, 32'd1);
    step();
    req1_valid = 1'b0;
    chk("r1_mult_a", mult_a, 32'h07);
    chk("r1_busy", busy, 32'd1);
    step();
    step();
    chk("r1_rsp_valid", rsp_valid, 32'd1);
    chk("r1_rsp_id", rsp_id, 32'd1);
    chk("r1_rsp_p", rsp_p, 32'h003F);

    // Reset one cycle after accept discards the in-flight op.
    req0_valid = 1'b1; req0_a = 8'h55; req0_b = 8'h55;
    step();
    req0_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_mult_a", mult_a, 32'd0);
    chk("mid_rst_mult_b", mult_b, 32'd0);
    chk("mid_rst_rsp_p", rsp_p, 32'd0);
    chk("mid_rst_rsp_id", rsp_id, 32'd0);
    chk("mid_rst_rsp_valid", rsp_valid, 32'd0);
    chk("mid_rst_busy", busy, 32'd0);
    step();
    rst_n = 1'b1;
    hits = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (rsp_valid) hits++;
    end
    chk("no_rsp_after_rst", hits, 32'd0);
    do_op("post_rst", 1'b0, 8'h00, 8'h7F, 16'h0000);

    // Latency of the MULT_LAT=0 and MULT_LAT=3 builds.
    x_valid = 1'b1; x_a = 8'hC3; x_b = 8'h5A;
    step();
    x_valid = 1'b0;
    lat0 = 0;
    lat3 = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (v0 && lat0 == 0) lat0 = k;
      if (v3 && lat3 == 0) lat3 = k;
    end
    chk("lat0_cycles", lat0, 32'd1);
    chk("lat3_cycles", lat3, 32'd4);
    chk("lat0_p", p0, 32'h448E);
    chk("lat3_p", p3, 32'h448E);
    chk("lat3_id", id3, 32'd0);
    chk("lat3_mult_a_hold", ma3, 32'hC3);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
